// File: rtl/register_bank_ab_if.sv
// register_bank_ab_if: bundles the register bank's write, read-select and
// operand-output signals.
//   master : datapath side. Drives RegWrite/WriteReg/WriteData/ReadReg1/ReadReg2/LoadAB
//            and receives ReadData1/ReadData2/WriteAck.
//   slave  : register bank side, with the opposite directions.
interface register_bank_ab_if #(
    parameter int DATA_W = 32
);
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [4:0]        ReadReg1;
    logic [4:0]        ReadReg2;
    logic              LoadAB;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              WriteAck;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LoadAB,
        input  ReadData1, ReadData2, WriteAck
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2, LoadAB,
        output ReadData1, ReadData2, WriteAck
    );
endinterface

// File: rtl/register_bank_ab.sv
// register_bank_ab_rd_port: one operand register (A or B). Selects between the
// bank contents and the write data that is being committed on the same edge.
// The result is then captured when load is high.
//   clk, reset : clock and asynchronous active-high reset
//   load       : capture enable
//   rd_idx     : source register index
//   bank_data  : current bank contents at rd_idx
//   wr_en      : write enable, wr_idx and wr_data : the write happening on this edge
//   rd_data    : registered operand
module register_bank_ab_rd_port #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [4:0]        rd_idx,
    input  logic [DATA_W-1:0] bank_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] fwd;

    // $zero wins over forwarding. A dropped write to reg 0 must not leak through.
    always_comb begin
        fwd = bank_data;
        if (rd_idx == 5'd0)
            fwd = '0;
        else if (wr_en && wr_idx == rd_idx)
            fwd = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else if (load)
            rd_data <= fwd;
    end
endmodule

// register_bank_ab: 32 x DATA_W register bank. It has one write port and two
// forwarded read ports. The read ports are latched into the A/B operand registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset. Clears the bank and sets reg 29 to SP_RESET.
//   bus   : register_bank_ab_if.slave
//           RegWrite/WriteReg/WriteData is the write port.
//           ReadReg1/ReadReg2/LoadAB selects and captures the operands.
//           ReadData1/ReadData2 are the registered operands A and B.
//           WriteAck pulses the cycle after a write that was committed.
module register_bank_ab #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227),
    parameter int                RA_INDEX = 31
) (
    input  logic                clk,
    input  logic                reset,
    register_bank_ab_if.slave   bus
);
    localparam int NUM_RD = 2;
    localparam int SP_IDX = 29;

    // RA_INDEX carries no behaviour. This only keeps it a legal register index.
    if (RA_INDEX < 1 || RA_INDEX > 31) begin : g_ra_chk
        $error("RA_INDEX must be a register index in 1..31");
    end

    logic [DATA_W-1:0]                 regs [32];
    logic                              wr_commit;
    logic [NUM_RD-1:0][4:0]            rd_idx;
    logic [NUM_RD-1:0][DATA_W-1:0]     bank_data;
    logic [NUM_RD-1:0][DATA_W-1:0]     rd_data;

    // Writes to reg 0 are dropped entirely, so regs[0] never leaves its reset value.
    assign wr_commit = bus.RegWrite && (bus.WriteReg != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
            bus.WriteAck <= 1'b0;
        end else begin
            bus.WriteAck <= wr_commit;
            if (wr_commit)
                regs[bus.WriteReg] <= bus.WriteData;
        end
    end

    assign rd_idx[0] = bus.ReadReg1;
    assign rd_idx[1] = bus.ReadReg2;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        assign bank_data[g] = regs[rd_idx[g]];

        register_bank_ab_rd_port #(.DATA_W(DATA_W)) u_rd (
            .clk       (clk),
            .reset     (reset),
            .load      (bus.LoadAB),
            .rd_idx    (rd_idx[g]),
            .bank_data (bank_data[g]),
            .wr_en     (bus.RegWrite),
            .wr_idx    (bus.WriteReg),
            .wr_data   (bus.WriteData),
            .rd_data   (rd_data[g])
        );
    end

    assign bus.ReadData1 = rd_data[0];
    assign bus.ReadData2 = rd_data[1];
endmodule

// File: tb/tb_register_bank_ab.sv
// Testbench for register_bank_ab. Runs directed scenarios followed by random
// traffic. The checks compare against an array model of the register file.
module tb_register_bank_ab;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    register_bank_ab_if #(.DATA_W(32)) bus();

    register_bank_ab dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [32];
    logic [31:0] exp_a, exp_b;
    logic        exp_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (mem[i]) mem[i] = 32'd0;
        mem[29] = 32'd227;
        exp_a = 32'd0;
        exp_b = 32'd0;
        exp_ack = 1'b0;
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.RegWrite && bus.WriteReg == r) return bus.WriteData;
        return mem[r];
    endfunction

    // Drive one cycle of inputs. On the edge, apply the rules to the model.
    // Shortly after the edge, compare the outputs with the model.
    task automatic step(input string tag, input logic rw, input logic [4:0] wr,
                        input logic [31:0] wd, input logic ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        logic [31:0] na, nb;
        bus.RegWrite  = rw;
        bus.WriteReg  = wr;
        bus.WriteData = wd;
        bus.LoadAB    = ld;
        bus.ReadReg1  = r1;
        bus.ReadReg2  = r2;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            na = fwd(r1);
            nb = fwd(r2);
            if (ld) begin
                exp_a = na;
                exp_b = nb;
            end
            exp_ack = rw && (wr != 5'd0);
            if (exp_ack) mem[wr] = wd;
        end
        #1;
        chk({tag, ".A"},   bus.ReadData1, exp_a);
        chk({tag, ".B"},   bus.ReadData2, exp_b);
        chk({tag, ".ack"}, {31'd0, bus.WriteAck}, {31'd0, exp_ack});
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
    endtask

    initial begin
        model_reset();
        bus.RegWrite = 1'b0; bus.WriteReg = '0; bus.WriteData = '0;
        bus.LoadAB = 1'b0; bus.ReadReg1 = '0; bus.ReadReg2 = '0;

        // Reset state. A write and a load while reset is high have no effect.
        #2;
        chk("rst.A",   bus.ReadData1, 32'd0);
        chk("rst.B",   bus.ReadData2, 32'd0);
        chk("rst.ack", {31'd0, bus.WriteAck}, 32'd0);
        step("rst_hold", 1'b1, 5'd29, 32'h55, 1'b1, 5'd29, 5'd29);
        #3 reset = 1'b0;

        // Reset value of the stack pointer, and $zero.
        step("sp", 1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd0);
        chk("sp.val", bus.ReadData1, 32'd227);

        // Write, acknowledge, then read back.
        step("wr8", 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
        chk("wr8.ack", {31'd0, bus.WriteAck}, 32'd1);
        step("rd8", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd29);
        chk("rd8.val", bus.ReadData1, 32'hDEADBEEF);

        // Same-edge forwarding to both ports.
        step("fwd5", 1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 5'd5);
        chk("fwd5.val", bus.ReadData2, 32'h12345678);

        // A write to $zero is dropped and produces no acknowledge.
        step("wr0", 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0);
        step("rd0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
        chk("rd0.val", bus.ReadData1, 32'd0);

        // Hold: A keeps its old value until the next load.
        step("ld8", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd8);
        step("hold", 1'b1, 5'd8, 32'h1, 1'b0, 5'd8, 5'd8);
        chk("hold.val", bus.ReadData1, 32'hDEADBEEF);
        idle("hold2");
        step("reld8", 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0);
        chk("reld8.val", bus.ReadData1, 32'h1);

        // Reset asserted between edges after reg 31 has been written.
        step("wr31", 1'b1, 5'd31, 32'h400, 1'b1, 5'd31, 5'd8);
        chk("wr31.fwd", bus.ReadData1, 32'h400);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async.A",   bus.ReadData1, 32'd0);
        chk("async.B",   bus.ReadData2, 32'd0);
        chk("async.ack", {31'd0, bus.WriteAck}, 32'd0);
        step("rst_wr", 1'b1, 5'd31, 32'h999, 1'b1, 5'd31, 5'd31);
        #3 reset = 1'b0;
        step("rd31", 1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd29);
        chk("rd31.val", bus.ReadData1, 32'd0);
        chk("rd29.val", bus.ReadData2, 32'd227);

        // Random traffic. Indices are biased toward a few registers so that
        // forwarding, $zero and repeated writes are exercised often.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr, r1, r2;
            wr = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            r2 = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom);
            step("rand", 1'($urandom), wr, $urandom, 1'($urandom_range(0, 3) != 0), r1, r2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
